fixedpoint_mul_pipe: RTL and testbench



---
 rtl/fxmul_pkg.sv | 23 ++
 rtl/fxmul_mag.sv | 15 +
 rtl/fixedpoint_mul_pipe.sv | 90 +++++++++
 tb/tb_fixedpoint_mul_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fxmul_pkg.sv
// Shared constants and helpers for the pipelined signed fixed-point multiplier.
package fxmul_pkg;

  localparam int DEF_IN_W     = 8;
  localparam int DEF_IN_FRAC  = 4;
  localparam int DEF_OUT_W    = 8;
  localparam int DEF_OUT_FRAC = 1;

  // Number of product fraction bits dropped to reach the output format
  function automatic int calc_sh(input int in_frac, input int out_frac);
    return 2 * in_frac - out_frac;
  endfunction

  function automatic bit sh_legal(input int in_frac, input int out_frac);
    return (out_frac >= 0) && (calc_sh(in_frac, out_frac) >= 1);
  endfunction

  // Rounded-magnitude width: wide enough for the product, the carry and both limits
  function automatic int calc_m_w(input int in_w, input int out_w);
    return ((2 * in_w > out_w) ? 2 * in_w : out_w) + 1;
  endfunction

endpackage

// File: rtl/fxmul_mag.sv
// Two's-complement to sign/magnitude; the most negative code maps to 2^(W-1) exactly.
module fxmul_mag
  import fxmul_pkg::*;
#(
  parameter int W = DEF_IN_W
) (
  input  logic [W-1:0] val,
  output logic         sign,
  output logic [W-1:0] mag
);

  assign sign = val[W-1];
  assign mag  = sign ? -val : val;

endmodule

// File: rtl/fixedpoint_mul_pipe.sv
// Three-stage signed fixed-point multiplier with valid/ready handshake.
// Define FXMUL_SAT_EN to clamp overflowing results instead of wrapping.
module fixedpoint_mul_pipe
  import fxmul_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int IN_FRAC  = DEF_IN_FRAC,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int OUT_FRAC = DEF_OUT_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_a,
  input  logic [IN_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int SH  = calc_sh(IN_FRAC, OUT_FRAC);
  localparam int P_W = 2 * IN_W;
  localparam int M_W = calc_m_w(IN_W, OUT_W);

  localparam logic [M_W-1:0] LIM_NEG = M_W'(1) << (OUT_W - 1);
  localparam logic [M_W-1:0] LIM_POS = LIM_NEG - M_W'(1);

  if (!sh_legal(IN_FRAC, OUT_FRAC)) begin : g_bad_sh
    $error("fixedpoint_mul_pipe: OUT_FRAC must satisfy 0 <= OUT_FRAC <= 2*IN_FRAC-1");
  end

  logic            adv;
  logic            sign_a, sign_b;
  logic [IN_W-1:0] mag_a, mag_b;

  logic            v1, neg1;
  logic [IN_W-1:0] ma1, mb1;
  logic            v2, neg2;
  logic [P_W-1:0]  p2;

  logic [M_W-1:0]   m, m_lim;
  logic             res_ovf;
  logic [OUT_W-1:0] res_data;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  fxmul_mag #(.W(IN_W)) u_mag_a (.val(in_a), .sign(sign_a), .mag(mag_a));
  fxmul_mag #(.W(IN_W)) u_mag_b (.val(in_b), .sign(sign_b), .mag(mag_b));

  // Rounding on the magnitude gives half-away-from-zero once the sign is reapplied
  always_comb begin
    m       = M_W'(p2 >> SH) + M_W'(p2[SH-1]);
    res_ovf = neg2 ? (m > LIM_NEG) : (m > LIM_POS);
    m_lim   = m;
`ifdef FXMUL_SAT_EN
    if (res_ovf) m_lim = neg2 ? LIM_NEG : LIM_POS;
`endif
    res_data = neg2 ? -m_lim[OUT_W-1:0] : m_lim[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      neg1      <= 1'b0;
      ma1       <= '0;
      mb1       <= '0;
      v2        <= 1'b0;
      neg2      <= 1'b0;
      p2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      neg1      <= sign_a ^ sign_b;
      ma1       <= mag_a;
      mb1       <= mag_b;
      v2        <= v1;
      neg2      <= neg1;
      p2        <= P_W'(ma1) * P_W'(mb1);
      out_valid <= v2;
      out_data  <= res_data;
      out_ovf   <= res_ovf;
    end
  end

endmodule

// File: tb/tb_fixedpoint_mul_pipe.sv
// Directed-vector bench for fixedpoint_mul_pipe (default and 12/6 -> 10/3 instances).
// Expected overflow results follow FXMUL_SAT_EN when it is defined for the build.
module tb_fixedpoint_mul_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [7:0] in_a, in_b, out_data;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_ovf2;
  logic [11:0] in_a2, in_b2;
  logic [9:0]  out_data2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixedpoint_mul_pipe u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  fixedpoint_mul_pipe #(.IN_W(12), .IN_FRAC(6), .OUT_W(10), .OUT_FRAC(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_ovf(out_ovf2)
  );

  typedef struct {
    logic        sel;
    logic [11:0] a;
    logic [11:0] b;
    logic [9:0]  d;
    logic        ovf;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    if (!vt[i].sel) begin
      @(negedge clk);
      in_a = vt[i].a[7:0]; in_b = vt[i].b[7:0]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d data", i), 32'(out_data), 32'(vt[i].d[7:0]));
      check($sformatf("vec%0d ovf", i), 32'(out_ovf), 32'(vt[i].ovf));
    end else begin
      @(negedge clk);
      check($sformatf("vec%0d in_ready2", i), 32'(in_ready2), 32'd1);
      in_a2 = vt[i].a; in_b2 = vt[i].b; in_valid2 = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b0;
      lat = 1;
      while (!out_valid2 && lat < 10) begin @(negedge clk); lat++; end
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d data", i), 32'(out_data2), 32'(vt[i].d));
      check($sformatf("vec%0d ovf", i), 32'(out_ovf2), 32'(vt[i].ovf));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nin, nout;
    logic stalled_prev;
    logic [7:0] held_d;
    logic held_o;

    vt[0]  = '{1'b0, 12'h018, 12'h020, 10'h006, 1'b0};  // 1.5 * 2.0 = 3.0
    vt[1]  = '{1'b0, 12'h01A, 12'h01C, 10'h006, 1'b0};  // 2.84375 rounds up to 3.0
    vt[2]  = '{1'b0, 12'h0E6, 12'h01C, 10'h0FA, 1'b0};  // -2.84375 rounds to -3.0
`ifdef FXMUL_SAT_EN
    vt[3]  = '{1'b0, 12'h080, 12'h080, 10'h07F, 1'b1};
`else
    vt[3]  = '{1'b0, 12'h080, 12'h080, 10'h080, 1'b1};
`endif
    vt[4]  = '{1'b0, 12'h080, 12'h07F, 10'h081, 1'b0};  // -63.5
    vt[5]  = '{1'b0, 12'h000, 12'h0AB, 10'h000, 1'b0};  // zero with negative operand
    vt[6]  = '{1'b0, 12'h0F8, 12'h008, 10'h0FF, 1'b0};  // -0.25 -> -0.5 (half away)
    vt[7]  = '{1'b0, 12'h07F, 12'h07F, 10'h07E, 1'b0};
    vt[8]  = '{1'b0, 12'h07F, 12'h081, 10'h082, 1'b0};
    vt[9]  = '{1'b0, 12'h010, 12'h010, 10'h002, 1'b0};  // 1.0 * 1.0
    vt[10] = '{1'b1, 12'hF80, 12'h060, 10'h3E8, 1'b0};  // -2.0 * 1.5 = -3.0
`ifdef FXMUL_SAT_EN
    vt[11] = '{1'b1, 12'h800, 12'h100, 10'h200, 1'b1};  // -128 clamps to -64
    vt[13] = '{1'b1, 12'h800, 12'hF80, 10'h1FF, 1'b1};  // +64 clamps to 63.875
`else
    vt[11] = '{1'b1, 12'h800, 12'h100, 10'h000, 1'b1};
    vt[13] = '{1'b1, 12'h800, 12'hF80, 10'h200, 1'b1};
`endif
    vt[12] = '{1'b1, 12'h800, 12'h080, 10'h200, 1'b0};  // exactly -64, no overflow

    rst_n = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_ovf", 32'(out_ovf), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid2", 32'(out_valid2), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-to-back stream with a four-cycle downstream stall
    @(negedge clk);
    nin = 0; nout = 0; stalled_prev = 1'b0; held_d = '0; held_o = 1'b0;
    for (int cyc = 0; cyc < 40 && nout < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (nin < 5) begin
        in_valid = 1'b1; in_a = vt[nin].a[7:0]; in_b = vt[nin].b[7:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        check($sformatf("stall hold data c%0d", cyc), 32'(out_data), 32'(held_d));
        check($sformatf("stall hold ovf c%0d", cyc), 32'(out_ovf), 32'(held_o));
      end
      if (cyc == 3) begin
        check("full out_valid", 32'(out_valid), 32'd1);
        check("full in_ready", 32'(in_ready), 32'd0);
      end
      stalled_prev = out_valid && !out_ready;
      held_d = out_data;
      held_o = out_ovf;
      if (out_valid && out_ready) begin
        check($sformatf("stream data %0d", nout), 32'(out_data), 32'(vt[nout].d[7:0]));
        check($sformatf("stream ovf %0d", nout), 32'(out_ovf), 32'(vt[nout].ovf));
        nout++;
      end
      if (in_valid && in_ready) nin++;
    end
    check("stream results", 32'(nout), 32'd5);
    check("stream accepts", 32'(nin), 32'd5);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("stream no duplicate", 32'(out_valid), 32'd0);

    // Reset with three results in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = vt[k].a[7:0]; in_b = vt[k].b[7:0];
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_data", 32'(out_data), 32'd0);
    check("mid reset out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    run_vec(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
